// File: rtl/yarp_dmem_mmio.sv
// yarp_dmem_mmio: data RAM plus memory-mapped 64-bit timer on the core data port
module yarp_dmem_mmio #(
  parameter logic [31:0] RAM_BASE  = 32'h0000_2000,
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_mem_req_i,
  input  logic [31:0] data_mem_addr_i,
  input  logic [1:0]  data_mem_byte_en_i,
  input  logic        data_mem_wr_i,
  input  logic [31:0] data_mem_wr_data_i,
  output logic [31:0] data_mem_rd_data_o,
  output logic        timer_irq_o,
  output logic        access_err_o
);
  localparam int AW = $clog2(RAM_WORDS);
  logic [31:0] mem [RAM_WORDS];
  logic [31:0] ram_off, mmio_off, ram_sh, wr_sh, mmio_rd;
  logic [AW-1:0] idx;
  logic [2:0] sel;
  logic [3:0] strb;
  logic ram_hit, mmio_hit, legal, ok, ram_we, mmio_we, tick;
  logic [63:0] mtime_q, mtime_d, cmp_q, cmp_d, mtime_inc;
  logic [15:0] pre_q, pre_d, pcnt_q, pcnt_d;
  logic en_q, en_d, irq_q, irq_d, err_q, err_d;
  always_comb begin
    ram_off   = data_mem_addr_i - RAM_BASE;
    mmio_off  = data_mem_addr_i - MMIO_BASE;
    ram_hit   = ram_off < 32'(RAM_WORDS * 4);
    mmio_hit  = mmio_off < 32'd24;
    legal     = (data_mem_byte_en_i != 2'b10)
              && !(data_mem_byte_en_i == 2'b01 && data_mem_addr_i[0])
              && !(data_mem_byte_en_i == 2'b11 && data_mem_addr_i[1:0] != 2'b00)
              && !(mmio_hit && data_mem_byte_en_i != 2'b11);
    ok        = data_mem_req_i && (ram_hit || mmio_hit) && legal;
    ram_we    = ok && ram_hit && data_mem_wr_i;
    mmio_we   = ok && mmio_hit && data_mem_wr_i;
    idx       = ram_off[AW+1:2];
    sel       = mmio_off[4:2];
    strb      = data_mem_byte_en_i == 2'b11 ? 4'hf
              : (data_mem_byte_en_i == 2'b01 ? 4'b0011 : 4'b0001) << data_mem_addr_i[1:0];
    wr_sh     = data_mem_wr_data_i << {data_mem_addr_i[1:0], 3'b000};
    ram_sh    = mem[idx] >> {data_mem_addr_i[1:0], 3'b000};
    mmio_rd   = sel == 3'd0 ? mtime_q[31:0]
              : sel == 3'd1 ? mtime_q[63:32]
              : sel == 3'd2 ? cmp_q[31:0]
              : sel == 3'd3 ? cmp_q[63:32]
              : sel == 3'd4 ? {31'b0, en_q}
              : {16'b0, pre_q};
    data_mem_rd_data_o = !ok ? 32'b0
              : mmio_hit ? mmio_rd
              : data_mem_byte_en_i == 2'b11 ? ram_sh
              : data_mem_byte_en_i == 2'b01 ? {16'b0, ram_sh[15:0]}
              : {24'b0, ram_sh[7:0]};
    tick      = en_q && pcnt_q == pre_q;
    mtime_inc = mtime_q + 64'd1;
    // a written half wins; the other half keeps its own tick result, carry from new data is not applied
    mtime_d   = {(mmio_we && sel == 3'd1) ? data_mem_wr_data_i : tick ? mtime_inc[63:32] : mtime_q[63:32],
                 (mmio_we && sel == 3'd0) ? data_mem_wr_data_i : tick ? mtime_inc[31:0] : mtime_q[31:0]};
    cmp_d     = {(mmio_we && sel == 3'd3) ? data_mem_wr_data_i : cmp_q[63:32],
                 (mmio_we && sel == 3'd2) ? data_mem_wr_data_i : cmp_q[31:0]};
    en_d      = (mmio_we && sel == 3'd4) ? data_mem_wr_data_i[0] : en_q;
    pre_d     = (mmio_we && sel == 3'd5) ? data_mem_wr_data_i[15:0] : pre_q;
    pcnt_d    = (mmio_we && (sel == 3'd4 || sel == 3'd5)) || tick ? 16'd0
              : en_q ? pcnt_q + 16'd1 : pcnt_q;
    irq_d     = en_d && mtime_d >= cmp_d;
    err_d     = data_mem_req_i && !ok;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mtime_q <= 64'd0;
      cmp_q   <= '1;
      en_q    <= 1'b0;
      pre_q   <= 16'd0;
      pcnt_q  <= 16'd0;
      irq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      mtime_q <= mtime_d;
      cmp_q   <= cmp_d;
      en_q    <= en_d;
      pre_q   <= pre_d;
      pcnt_q  <= pcnt_d;
      irq_q   <= irq_d;
      err_q   <= err_d;
    end
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (ram_we && strb[i]) mem[idx][8*i +: 8] <= wr_sh[8*i +: 8];
  assign timer_irq_o  = irq_q;
  assign access_err_o = err_q;
endmodule
